// File: rtl/css_mcu0_dmi_tgt_bridge.sv
// DMI-to-debug-target bridge: turns single-cycle DMI strobes into held
// req/ack transactions, with a timeout, a local status register and sticky errors.
module css_mcu0_dmi_tgt_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [6:0]  STATUS_ADDR = 7'h7F
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [6:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] rd_data,
  output logic        tgt_req,
  output logic        tgt_we,
  output logic [6:0]  tgt_addr,
  output logic [31:0] tgt_wdata,
  input  logic        tgt_ack,
  input  logic [31:0] tgt_rdata,
  input  logic        tgt_err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AW     = 7;
  localparam int unsigned DW     = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             berr_q;
  logic             terr_q;
  logic             tout_q;
  logic             tgt_we_q;
  logic [AW-1:0]    tgt_addr_q;
  logic [DW-1:0]    tgt_wdata_q;
  logic [DW-1:0]    rd_data_q;

  logic             in_req;
  logic             st_access;
  logic             fwd_access;
  logic             done_ack;
  logic             done_tout;
  logic             berr_set;
  logic             terr_set;
  logic [2:0]       st_clr;
  logic [DW-1:0]    status_val;

  // Access decode, completion events and the live status word
  always_comb begin
    in_req     = (state_q == REQ);
    st_access  = reg_en && (reg_wr_addr == STATUS_ADDR);
    fwd_access = reg_en && (reg_wr_addr != STATUS_ADDR);
    done_ack   = in_req && tgt_ack;
    done_tout  = in_req && !tgt_ack && (cnt_q == CNT_LAST);
    berr_set   = in_req && fwd_access;
    terr_set   = done_ack && tgt_err;
    st_clr     = (st_access && reg_wr_en) ? reg_wr_data[3:1] : 3'b000;
    status_val = {28'd0, tout_q, terr_q, berr_q, in_req};
  end

  // Transaction FSM, timeout counter, sticky flags and held read data
  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      berr_q      <= 1'b0;
      terr_q      <= 1'b0;
      tout_q      <= 1'b0;
      tgt_we_q    <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      // Set beats clear when both land on the same cycle
      berr_q <= (berr_q & ~st_clr[0]) | berr_set;
      terr_q <= (terr_q & ~st_clr[1]) | terr_set;
      tout_q <= (tout_q & ~st_clr[2]) | done_tout;

      case (state_q)
        IDLE: begin
          if (fwd_access) begin
            tgt_we_q    <= reg_wr_en;
            tgt_addr_q  <= reg_wr_addr;
            tgt_wdata_q <= reg_wr_data;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (done_ack || done_tout) begin
            state_q <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Target completion takes precedence over a status read in the same cycle
      if (done_ack && !tgt_we_q) begin
        rd_data_q <= tgt_rdata;
      end else if (done_tout && !tgt_we_q) begin
        rd_data_q <= '1;
      end else if (st_access && !reg_wr_en) begin
        rd_data_q <= status_val;
      end
    end
  end

  assign tgt_req   = in_req;
  assign tgt_we    = tgt_we_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;
  assign rd_data   = rd_data_q;

endmodule
